// File: rtl/iob_dma_mem_arbiter_if.sv
// Shared-memory bus bundle: N_M native masters on one side, one simple-RAM
// slave on the other, plus arbiter status (grant/busy).
interface iob_dma_mem_arbiter_if #(
   parameter int N_M    = 4,
   parameter int ADDR_W = 24,
   parameter int DATA_W = 32
);
   logic [N_M-1:0]            m_valid;
   logic [N_M*ADDR_W-1:0]     m_addr;
   logic [N_M*DATA_W-1:0]     m_wdata;
   logic [N_M*DATA_W/8-1:0]   m_wstrb;
   logic [N_M*DATA_W-1:0]     m_rdata;
   logic [N_M-1:0]            m_ready;
   logic                      s_valid;
   logic [ADDR_W-1:0]         s_addr;
   logic [DATA_W-1:0]         s_wdata;
   logic [DATA_W/8-1:0]       s_wstrb;
   logic [DATA_W-1:0]         s_rdata;
   logic                      s_ready;
   logic [N_M-1:0]            grant;
   logic                      busy;

   // Arbiter side
   modport slave (
      input  m_valid, m_addr, m_wdata, m_wstrb, s_rdata, s_ready,
      output m_rdata, m_ready, s_valid, s_addr, s_wdata, s_wstrb, grant, busy
   );

   // Environment side: masters plus the memory
   modport master (
      output m_valid, m_addr, m_wdata, m_wstrb, s_rdata, s_ready,
      input  m_rdata, m_ready, s_valid, s_addr, s_wdata, s_wstrb, grant, busy
   );
endinterface

// File: rtl/iob_dma_mem_arbiter.sv
// Round-robin arbiter sharing one native memory port among N_M masters, one
// transaction in flight; RELEASE swallows the trailing registered-ready pulse.
module iob_dma_mem_arbiter #(
   parameter int N_M    = 4,
   parameter int ADDR_W = 24,
   parameter int DATA_W = 32
) (
   input logic                  clk,
   input logic                  rst,
   iob_dma_mem_arbiter_if.slave bus
);
   localparam int IDX_W = (N_M > 1) ? $clog2(N_M) : 1;
   localparam int STB_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t           state_q;
   logic [IDX_W-1:0] ptr_q, gnt_idx_q, ptr_d, sel_idx;
   logic [IDX_W:0]   cand;
   logic             sel_found;
   logic [N_M-1:0]   grant_q;
   logic             busy_q;
   logic             in_grant;

   // First requester scanning ptr, ptr+1, ... with explicit wrap at N_M
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int i = 0; i < N_M; i++) begin
         cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
         if (cand >= (IDX_W+1)'(N_M)) cand = cand - (IDX_W+1)'(N_M);
         if (!sel_found && bus.m_valid[cand[IDX_W-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = cand[IDX_W-1:0];
         end
      end
   end

   assign ptr_d    = (gnt_idx_q == IDX_W'(N_M-1)) ? '0 : gnt_idx_q + 1'b1;
   assign in_grant = (state_q == GRANT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         gnt_idx_q <= '0;
         grant_q   <= '0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (sel_found) begin
               gnt_idx_q <= sel_idx;
               grant_q   <= N_M'(1) << sel_idx;
               busy_q    <= 1'b1;
               state_q   <= GRANT;
            end
            // Completion takes priority over a same-cycle abort
            GRANT: if (bus.s_ready) begin
               ptr_q   <= ptr_d;
               state_q <= RELEASE;
            end else if (!bus.m_valid[gnt_idx_q]) begin
               state_q <= RELEASE;
            end
            RELEASE: begin
               grant_q <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               grant_q <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Datapath muxing is combinational so an async reset clears it at once
   always_comb begin
      bus.s_valid = 1'b0;
      bus.s_addr  = '0;
      bus.s_wdata = '0;
      bus.s_wstrb = '0;
      bus.m_ready = '0;
      bus.m_rdata = '0;
      if (in_grant) begin
         bus.s_valid = bus.m_valid[gnt_idx_q];
         bus.s_addr  = bus.m_addr[gnt_idx_q*ADDR_W +: ADDR_W];
         bus.s_wdata = bus.m_wdata[gnt_idx_q*DATA_W +: DATA_W];
         bus.s_wstrb = bus.m_wstrb[gnt_idx_q*STB_W +: STB_W];
         bus.m_ready[gnt_idx_q] = bus.s_ready;
         bus.m_rdata[gnt_idx_q*DATA_W +: DATA_W] = bus.s_rdata;
      end
   end

   assign bus.grant = grant_q;
   assign bus.busy  = busy_q;
endmodule
